sonic_circbuf_read_ctrl: RTL

//  Read-side controller for the SONIC circular buffer. Arbitrates two readers
//  (0 = DMA, 1 = host/debug), walks each granted burst across the 64-page external

---
 rtl/sonic_circbuf_pkg.sv | 22 ++
 rtl/sonic_rdctrl_fifo.sv | 56 +++++
 rtl/sonic_circbuf_read_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sonic_circbuf_pkg.sv
// Shared constants, FSM state and in-flight tag types for the SONIC circular-buffer read side.
package sonic_circbuf_pkg;

    localparam int unsigned EXT_PAGES     = 64;
    localparam logic [14:0] PAGE_WORDS    = 15'h1F0;
    localparam logic [14:0] EXT_ADDR_END  = 15'(EXT_PAGES * PAGE_WORDS);
    localparam int unsigned TRANSLATE_LAT = 4;

    typedef enum logic [1:0] {IDLE, GRANT, ISSUE, DRAIN} rdctrl_state_t;

    typedef struct packed {
        logic valid;
        logic src;
        logic last;
    } pipe_tag_t;

    // Walk the external space linearly, wrapping from the last valid word back to 0.
    function automatic logic [14:0] next_ext_addr(input logic [14:0] addr);
        return (addr == EXT_ADDR_END - 15'd1) ? 15'd0 : addr + 15'd1;
    endfunction

endpackage

// File: rtl/sonic_rdctrl_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally on o_rdata.
module sonic_rdctrl_fifo #(
    parameter int unsigned WIDTH = 130,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sonic_circbuf_read_ctrl.sv
// Two-reader burst read controller: round-robin grant, credit-limited issue, output FIFO.
// Optional per-reader popped-word counters on o_stat_words when SONIC_RDCTRL_STATS_EN is defined.
module sonic_circbuf_read_ctrl
    import sonic_circbuf_pkg::*;
#(
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned PIPE_LAT   = TRANSLATE_LAT + 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_req,
    input  logic [29:0]       i_req_start,
    input  logic [29:0]       i_req_len,
    output logic [1:0]        o_req_ack,
    output logic [1:0]        o_req_done,
    output logic              o_req_err,
    output logic [14:0]       o_rd_ext_addr,
    output logic              o_rd_en,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_src,
    output logic              o_out_last,
    input  logic              i_out_ready,
    output logic              o_busy
`ifdef SONIC_RDCTRL_STATS_EN
    ,
    output logic [63:0]       o_stat_words
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    rdctrl_state_t   r_state;
    logic            r_prio;
    logic            r_owner;
    logic [14:0]     r_addr;
    logic [14:0]     r_remain;
    logic [1:0]      r_req_ack;
    logic [1:0]      r_req_done;
    logic            r_req_err;
    logic            r_rd_en;
    logic [14:0]     r_rd_ext_addr;
    logic            r_rd_src;
    logic            r_rd_last;
    pipe_tag_t       r_pipe [PIPE_LAT];

    logic [CW-1:0]     w_fifo_count;
    logic [DATA_W+1:0] w_head;
    logic              w_pop;
    logic              w_drain_done;
    logic              w_winner;
    logic [31:0]       w_outstanding;
    logic              w_credit_ok;
    pipe_tag_t         w_tail;

    assign w_winner = (i_req == 2'b11) ? r_prio : i_req[1];
    assign w_tail   = r_pipe[PIPE_LAT-1];
    assign w_pop    = o_out_valid & i_out_ready;
    assign w_drain_done = (r_state == DRAIN) && w_pop && w_head[DATA_W];

    // Everything already committed to a FIFO slot: stored, in the pipe, or on the rd_en register.
    always_comb begin
        w_outstanding = 32'(w_fifo_count) + 32'(r_rd_en);
        for (int i = 0; i < int'(PIPE_LAT); i++) begin
            w_outstanding = w_outstanding + 32'(r_pipe[i].valid);
        end
    end
    assign w_credit_ok = w_outstanding < FIFO_DEPTH;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_prio        <= 1'b0;
            r_owner       <= 1'b0;
            r_addr        <= '0;
            r_remain      <= '0;
            r_req_ack     <= '0;
            r_req_done    <= '0;
            r_req_err     <= 1'b0;
            r_rd_en       <= 1'b0;
            r_rd_ext_addr <= '0;
            r_rd_src      <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_req_ack  <= '0;
            r_req_done <= '0;
            r_req_err  <= 1'b0;
            r_rd_en    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_owner   <= w_winner;
                        r_prio    <= ~w_winner;
                        r_addr    <= w_winner ? i_req_start[29:15] : i_req_start[14:0];
                        r_remain  <= w_winner ? i_req_len[29:15] : i_req_len[14:0];
                        r_req_ack <= w_winner ? 2'b10 : 2'b01;
                        r_state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (r_remain == '0) begin
                        r_req_done <= r_owner ? 2'b10 : 2'b01;
                        r_state    <= IDLE;
                    end else if (r_addr >= EXT_ADDR_END) begin
                        r_req_done <= r_owner ? 2'b10 : 2'b01;
                        r_req_err  <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_credit_ok) begin
                        r_rd_en       <= 1'b1;
                        r_rd_ext_addr <= r_addr;
                        r_rd_src      <= r_owner;
                        r_rd_last     <= (r_remain == 15'd1);
                        r_addr        <= next_ext_addr(r_addr);
                        r_remain      <= r_remain - 15'd1;
                        if (r_remain == 15'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Fixed-latency tag pipe mirrors the translator+RAM so each returning word knows its owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(PIPE_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: r_rd_en, src: r_rd_src, last: r_rd_last};
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    sonic_rdctrl_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_tail.valid),
        .i_wdata ({w_tail.src, w_tail.last, i_ram_rdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_count)
    );

    always_comb begin
        o_req_ack     = r_req_ack;
        o_req_err     = r_req_err;
        o_rd_en       = r_rd_en;
        o_rd_ext_addr = r_rd_ext_addr;
        o_busy        = (r_state != IDLE);
        o_out_valid   = (w_fifo_count != '0);
        o_out_data    = o_out_valid ? w_head[DATA_W-1:0] : '0;
        o_out_last    = o_out_valid & w_head[DATA_W];
        o_out_src     = o_out_valid & w_head[DATA_W+1];
        o_req_done    = r_req_done;
        if (w_drain_done) begin
            o_req_done = r_owner ? 2'b10 : 2'b01;
        end
    end

`ifdef SONIC_RDCTRL_STATS_EN
    logic [31:0] r_stat [2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat[0] <= '0;
            r_stat[1] <= '0;
        end else if (w_pop && (r_stat[w_head[DATA_W+1]] != 32'hFFFF_FFFF)) begin
            r_stat[w_head[DATA_W+1]] <= r_stat[w_head[DATA_W+1]] + 32'd1;
        end
    end

    assign o_stat_words = {r_stat[1], r_stat[0]};
`endif

endmodule
